// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - handshaked ALU with bit-serial shifts
// Optional ALU_ITER_SLTU_EN adds unsigned less-than on opcode 1010.
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand_0,
    input  logic [WIDTH-1:0] operand_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal_op
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
`ifdef ALU_ITER_SLTU_EN
    localparam logic [3:0] OP_SLTU = 4'b1010;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic            illegal_q, illegal_d;

    logic [SW-1:0]   amount;
    assign amount = operand_1[SW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= 4'b0000;
            work_q    <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d      = opcode;
                    illegal_d = 1'b0;
                    state_d   = DONE;
                    case (opcode)
                        OP_ADD:  work_d = operand_0 + operand_1;
                        OP_SUB:  work_d = operand_0 - operand_1;
                        OP_AND:  work_d = operand_0 & operand_1;
                        OP_OR:   work_d = operand_0 | operand_1;
                        OP_XOR:  work_d = operand_0 ^ operand_1;
                        OP_SLT:  work_d = {{(WIDTH-1){1'b0}}, $signed(operand_0) < $signed(operand_1)};
`ifdef ALU_ITER_SLTU_EN
                        OP_SLTU: work_d = {{(WIDTH-1){1'b0}}, operand_0 < operand_1};
`endif
                        OP_SLL, OP_SRL, OP_SRA: begin
                            // Zero-amount shifts bypass SHIFT and return operand_0 directly
                            work_d = operand_0;
                            cnt_d  = amount;
                            if (amount != '0) begin
                                state_d = SHIFT;
                            end
                        end
                        default: begin
                            work_d    = '0;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT: begin
                case (op_q)
                    OP_SLL:  work_d = {work_q[WIDTH-2:0], 1'b0};
                    OP_SRL:  work_d = {1'b0, work_q[WIDTH-1:1]};
                    default: work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                endcase
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign result     = work_q;
    assign illegal_op = illegal_q;
endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - scoreboard bench for alu_iter with a behavioural reference model
module tb_alu_iter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [31:0] operand_0;
    logic [31:0] operand_1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal_op;

    alu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operand_0(operand_0), .operand_1(operand_1),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        il;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   bp      = 0;
    bit   seen    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference: the operation's meaning in plain arithmetic, plus its latency in extra cycles
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic il, output int lat);
        int sh;
        sh  = int'(b % 32);
        il  = 1'b0;
        lat = 0;
        r   = 32'h0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd6: begin r = a << sh; lat = sh; end
            4'd7: begin r = a >> sh; lat = sh; end
            4'd8: begin r = $signed(a) >>> sh; lat = sh; end
            4'd9: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_ITER_SLTU_EN
            4'd10: r = (a < b) ? 32'd1 : 32'd0;
`endif
            default: il = 1'b1;
        endcase
    endfunction

    // Monitor: compares every cycle a result is presented, so held results are also checked
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
                    out_ready = 1'b1;
                end else begin
                    e = q[0];
                    chk("result", result, e.r);
                    chk("illegal_op", {31'b0, illegal_op}, {31'b0, e.il});
                    chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
                    if (!seen) begin
                        chk("latency", 32'(cyc - e.acc), 32'(e.lat + 1));
                        seen = 1;
                    end
                    if (bp > 0) begin
                        out_ready = 1'b0;
                        bp--;
                    end else begin
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end else begin
                out_ready = $urandom_range(0, 1) != 0;
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   t = 0;
        @(negedge clk);
        opcode = op; operand_0 = a; operand_1 = b; in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        chk("accept_after_pop", 32'(q.size()), 32'd0);
        model(op, a, b, e.r, e.il, e.lat);
        e.acc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        opcode    = 4'($urandom);
        operand_0 = $urandom;
        operand_1 = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; opcode = 4'h0;
        operand_0 = 32'h0; operand_1 = 32'h0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_illegal", {31'b0, illegal_op}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0002);
        issue(4'd1, 32'h0000_0000, 32'h0000_0001);
        issue(4'd9, 32'h8000_0000, 32'h0000_0001);
        issue(4'd9, 32'h0000_0005, 32'hFFFF_FFFF);
        issue(4'd10, 32'h8000_0000, 32'h0000_0001);
        issue(4'd10, 32'h0000_0005, 32'hFFFF_FFFF);
        issue(4'd8, 32'h8000_0000, 32'd4);
        issue(4'd7, 32'h8000_0000, 32'd4);
        issue(4'd6, 32'h0000_0001, 32'd31);
        issue(4'd6, 32'h1234_5678, 32'd0);
        issue(4'd7, 32'hF000_0000, 32'd33);
        issue(4'd5, 32'hDEAD_BEEF, 32'h1);
        issue(4'd15, 32'hDEAD_BEEF, 32'h1);
        drain();

        bp = 10;
        issue(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(4'd3, 32'h0000_00F0, 32'h0000_000F);
        drain();

        // Asynchronous reset mid-shift discards the operation
        issue(4'd6, 32'h0000_0001, 32'd20);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        q.delete();
        seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'd0, 32'h0000_0010, 32'h0000_0020);
        drain();

        for (int i = 0; i < 150; i++) begin
            issue(4'($urandom), $urandom, $urandom);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
